// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame parser: sync byte, FSM encoding and checksum rule.
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LEN     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_CHK     = 2'd3;

    // A frame is good when LEN + payload + CHK sums to this value modulo 256.
    localparam int unsigned CHK_W    = 8;
    localparam logic [7:0]  CHK_GOOD = 8'h00;

    function automatic logic chk_ok(input logic [CHK_W-1:0] sum, input logic [CHK_W-1:0] chk);
        logic [CHK_W-1:0] total;
        total = sum + chk;
        return total == CHK_GOOD;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter; only built when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 480000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic run,
    input  logic kick,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;

    // A byte in the expiry cycle wins, so expiry is masked by kick.
    assign expired = run && !kick && (count_q == CNT_MAX);

    always_comb begin
        count_d = count_q;
        if (!run || kick) begin
            count_d = '0;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Byte-stream framer: SYNC | LEN | payload | CHK, publishes validated frames.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int unsigned DBITS          = 8,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned LEN_BITS       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 480000
) (
    input  logic                      clk_100MHz,
    input  logic                      reset,
    input  logic [DBITS-1:0]          rx_data,
    input  logic                      rx_valid,
    output logic                      frame_valid,
    output logic [LEN_BITS-1:0]       frame_len,
    output logic [DBITS*MAX_LEN-1:0]  frame_data,
    output logic                      err_chk,
    output logic                      err_len,
    output logic                      err_timeout,
    output logic                      busy
);

    logic [1:0]                        state_q, state_d;
    logic [LEN_BITS-1:0]               len_q, len_d;
    logic [LEN_BITS-1:0]               idx_q, idx_d;
    logic [CHK_W-1:0]                  sum_q, sum_d;
    logic [MAX_LEN-1:0][DBITS-1:0]     buf_q, buf_d;
    logic [MAX_LEN-1:0][DBITS-1:0]     frame_data_q, frame_data_d;
    logic [LEN_BITS-1:0]               frame_len_q, frame_len_d;
    logic                              frame_valid_q, frame_valid_d;
    logic                              err_chk_q, err_chk_d;
    logic                              err_len_q, err_len_d;
    logic                              err_timeout_q, err_timeout_d;
    logic                              timeout_hit;

`ifdef UART_FRAME_TIMEOUT_EN
    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .run       (state_q != S_IDLE),
        .kick      (rx_valid),
        .expired   (timeout_hit)
    );
`else
    logic unused_cfg;
    assign unused_cfg  = TIMEOUT_CYCLES[0];
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        buf_d         = buf_q;
        frame_data_d  = frame_data_q;
        frame_len_d   = frame_len_q;
        frame_valid_d = 1'b0;
        err_chk_d     = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) state_d = S_LEN;
                end
                S_LEN: begin
                    len_d = LEN_BITS'(rx_data);
                    sum_d = CHK_W'(rx_data);
                    if (LEN_BITS'(rx_data) > LEN_BITS'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        // Cleared even for LEN==0 so an empty frame publishes all-zero data.
                        buf_d   = '0;
                        idx_d   = '0;
                        state_d = (LEN_BITS'(rx_data) == '0) ? S_CHK : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    for (int i = 0; i < int'(MAX_LEN); i++) begin
                        if (idx_q == LEN_BITS'(i)) buf_d[i] = rx_data;
                    end
                    sum_d = sum_q + CHK_W'(rx_data);
                    idx_d = idx_q + LEN_BITS'(1);
                    if (idx_q == len_q - LEN_BITS'(1)) state_d = S_CHK;
                end
                S_CHK: begin
                    if (chk_ok(sum_q, CHK_W'(rx_data))) begin
                        frame_data_d  = buf_q;
                        frame_len_d   = len_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        err_chk_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (timeout_hit) begin
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            sum_q         <= '0;
            buf_q         <= '0;
            frame_data_q  <= '0;
            frame_len_q   <= '0;
            frame_valid_q <= 1'b0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            buf_q         <= buf_d;
            frame_data_q  <= frame_data_d;
            frame_len_q   <= frame_len_d;
            frame_valid_q <= frame_valid_d;
            err_chk_q     <= err_chk_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_len   = frame_len_q;
    assign frame_data  = frame_data_q;
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser; timeout scenario follows UART_FRAME_TIMEOUT_EN.
module tb_uart_frame_parser;

    logic         clk_100MHz = 1'b0;
    logic         reset      = 1'b1;
    logic [7:0]   rx_data    = 8'h00;
    logic         rx_valid   = 1'b0;
    logic         frame_valid, err_chk, err_len, err_timeout, busy;
    logic [7:0]   frame_len;
    logic [127:0] frame_data;

    int tests_run = 0;
    int fails     = 0;
    int n_fv = 0, n_ec = 0, n_el = 0, n_et = 0, n_multi = 0;

    uart_frame_parser #(
        .DBITS(8), .MAX_LEN(16), .LEN_BITS(8), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_valid(frame_valid),
        .frame_len  (frame_len),
        .frame_data (frame_data),
        .err_chk    (err_chk),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .busy       (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Pulse monitor sampled just after each edge.
    always @(posedge clk_100MHz) begin
        #1;
        if (frame_valid) n_fv++;
        if (err_chk) n_ec++;
        if (err_len) n_el++;
        if (err_timeout) n_et++;
        if (int'(frame_valid) + int'(err_chk) + int'(err_len) + int'(err_timeout) > 1) n_multi++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk_100MHz);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_100MHz);
            rx_valid = 1'b0;
            rx_data  = 8'h00;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        tests_run++;
        if ({frame_valid, err_chk, err_len, err_timeout, busy} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b exp 00000", {frame_valid, err_chk, err_len, err_timeout, busy});
        end
        tests_run++;
        if (frame_data !== 128'h0 || frame_len !== 8'h0) begin
            fails++; $display("FAIL reset_data: got len %h data %h exp 0", frame_len, frame_data);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        tests_run++;
        if (busy !== 1'b1) begin fails++; $display("FAIL good_busy: got %b exp 1", busy); end
        send(8'h97);
        idle(1);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_len !== 8'd3 || frame_data !== 128'h332211) begin
            fails++; $display("FAIL good_frame: got fv %b len %0d data %h exp 1 3 332211", frame_valid, frame_len, frame_data);
        end
        idle(1);
        tests_run++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL good_pulse_width: got fv %b busy %b exp 0 0", frame_valid, busy);
        end
        // 0x69 + 0x87 = 0xF0, not a valid checksum.
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h87);
        idle(1);
        tests_run++;
        if (err_chk !== 1'b1 || frame_valid !== 1'b0 || frame_data !== 128'h332211) begin
            fails++; $display("FAIL off_by_chk: got ec %b fv %b data %h exp 1 0 332211", err_chk, frame_valid, frame_data);
        end
        idle(1);
    endtask

    task automatic test_bad_chk;
        int fv0;
        fv0 = n_fv;
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        idle(1);
        tests_run++;
        if (err_chk !== 1'b1 || frame_valid !== 1'b0) begin
            fails++; $display("FAIL bad_chk: got ec %b fv %b exp 1 0", err_chk, frame_valid);
        end
        idle(2);
        tests_run++;
        if (n_fv != fv0 || frame_data !== 128'h332211 || frame_len !== 8'd3) begin
            fails++; $display("FAIL bad_chk_hold: got fvs %0d len %0d data %h exp %0d 3 332211", n_fv, frame_len, frame_data, fv0);
        end
    endtask

    task automatic test_len_err;
        send(8'hA5); send(8'h11);
        idle(1);
        tests_run++;
        if (err_len !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL len_err: got el %b busy %b exp 1 0", err_len, busy);
        end
        send(8'hA5); send(8'h01); send(8'h5A); send(8'hA5);
        idle(1);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_len !== 8'd1 || frame_data !== 128'h5A) begin
            fails++; $display("FAIL len_err_recover: got fv %b len %0d data %h exp 1 1 5a", frame_valid, frame_len, frame_data);
        end
        idle(1);
    endtask

    task automatic test_noise_zero_len;
        int p0;
        p0 = n_fv + n_ec + n_el + n_et;
        send(8'h00); send(8'hFF);
        idle(2);
        tests_run++;
        if (busy !== 1'b0 || n_fv + n_ec + n_el + n_et != p0) begin
            fails++; $display("FAIL noise: got busy %b pulses %0d exp 0 %0d", busy, n_fv + n_ec + n_el + n_et, p0);
        end
        send(8'hA5); send(8'h00); send(8'h00);
        idle(1);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_len !== 8'd0 || frame_data !== 128'h0) begin
            fails++; $display("FAIL zero_len: got fv %b len %0d data %h exp 1 0 0", frame_valid, frame_len, frame_data);
        end
        send(8'hA5); send(8'h02); send(8'hA5); send(8'hA5); send(8'hB4);
        idle(1);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_len !== 8'd2 || frame_data !== 128'hA5A5) begin
            fails++; $display("FAIL sync_in_payload: got fv %b len %0d data %h exp 1 2 a5a5", frame_valid, frame_len, frame_data);
        end
        idle(1);
    endtask

    task automatic test_max_len;
        logic [127:0] exp_data;
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            send(8'(i + 1));
            exp_data[i*8 +: 8] = 8'(i + 1);
        end
        // 0x10 + sum(1..16)=0x88 -> 0x98; 0x98 + 0x68 = 0x100.
        send(8'h68);
        idle(1);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_len !== 8'd16 || frame_data !== exp_data) begin
            fails++; $display("FAIL max_len: got fv %b len %0d data %h exp 1 16 %h", frame_valid, frame_len, frame_data, exp_data);
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        send(8'hA5); send(8'h01); send(8'h5A); send(8'hA5);
        send(8'hA5);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_data !== 128'h5A) begin
            fails++; $display("FAIL b2b_first: got fv %b data %h exp 1 5a", frame_valid, frame_data);
        end
        send(8'h02); send(8'h01); send(8'h02); send(8'hFB);
        idle(1);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_len !== 8'd2 || frame_data !== 128'h0201) begin
            fails++; $display("FAIL b2b_second: got fv %b len %0d data %h exp 1 2 0201", frame_valid, frame_len, frame_data);
        end
        idle(1);
    endtask

    task automatic test_timeout;
        int et0;
        et0 = n_et;
`ifdef UART_FRAME_TIMEOUT_EN
        send(8'hA5); send(8'h02); send(8'h11);
        idle(101);
        tests_run++;
        if (n_et != et0 || busy !== 1'b1) begin
            fails++; $display("FAIL timeout_early: got ets %0d busy %b exp %0d 1", n_et, busy, et0);
        end
        idle(1);
        tests_run++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL timeout_fire: got et %b busy %b exp 1 0", err_timeout, busy);
        end
        idle(2);
        et0 = n_et;
        send(8'hA5); send(8'h02); send(8'h11);
        idle(100);
        send(8'h22);
        idle(100);
        send(8'hCB);
        idle(1);
        tests_run++;
        if (frame_valid !== 1'b1 || n_et != et0 || frame_data !== 128'h2211) begin
            fails++; $display("FAIL timeout_edge_byte: got fv %b ets %0d data %h exp 1 %0d 2211", frame_valid, n_et, frame_data, et0);
        end
`else
        send(8'hA5); send(8'h02); send(8'h11);
        idle(300);
        tests_run++;
        if (n_et != et0 || busy !== 1'b1) begin
            fails++; $display("FAIL stall_no_timeout: got ets %0d busy %b exp %0d 1", n_et, busy, et0);
        end
        send(8'h22); send(8'hCB);
        idle(1);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_data !== 128'h2211) begin
            fails++; $display("FAIL stall_resume: got fv %b data %h exp 1 2211", frame_valid, frame_data);
        end
`endif
        idle(1);
    endtask

    task automatic test_reset_mid;
        int p0;
        send(8'hA5); send(8'h03); send(8'h11);
        @(negedge clk_100MHz);
        rx_valid = 1'b0;
        reset    = 1'b1;
        p0 = n_fv + n_ec + n_el + n_et;
        @(negedge clk_100MHz);
        reset = 1'b0;
        idle(3);
        tests_run++;
        if (busy !== 1'b0 || n_fv + n_ec + n_el + n_et != p0 || frame_data !== 128'h0) begin
            fails++; $display("FAIL reset_mid: got busy %b pulses %0d data %h exp 0 %0d 0", busy, n_fv + n_ec + n_el + n_et, p0, frame_data);
        end
        send(8'hA5); send(8'h01); send(8'h5A); send(8'hA5);
        idle(1);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_len !== 8'd1 || frame_data !== 128'h5A) begin
            fails++; $display("FAIL reset_mid_recover: got fv %b len %0d data %h exp 1 1 5a", frame_valid, frame_len, frame_data);
        end
        idle(2);
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_chk;
        test_len_err;
        test_noise_zero_len;
        test_max_len;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        tests_run++;
        if (n_multi != 0) begin
            fails++; $display("FAIL onehot_pulses: got %0d overlapping cycles exp 0", n_multi);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
